// File: rtl/cmp_arbiter.sv
// Two-port arbiter/sequencer for the shared set-compare subtractor (IDLE -> EXEC -> HOLD).
// Define CMP_RR_EN for round-robin arbitration; otherwise port 0 wins every tie.
module cmp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_set,
    output logic             res_id,
    output logic             res_err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_SNE = 3'b001;
    localparam logic [2:0] OP_SGE = 3'b010;
    localparam logic [2:0] OP_SLE = 3'b011;
    localparam logic [2:0] OP_SGT = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    state_t           state;
    state_t           state_nxt;
    logic             grant;
    logic             grant_id;
    logic [2:0]       op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             id_p0;
    logic [WIDTH-1:0] sub_x;
    logic [WIDTH-1:0] sub_y;
    logic [WIDTH:0]   sub_sum;
    logic             sub_cout;
    logic             sub_zero;

    function automatic logic cmp_set(input logic [2:0] op, input logic zero, input logic cout);
        logic set;
        case (op)
            OP_SEQ:  set = zero;
            OP_SNE:  set = ~zero;
            OP_SGE:  set = cout;
            OP_SLE:  set = cout;
            OP_SGT:  set = cout & ~zero;
            OP_SLT:  set = ~cout;
            default: set = 1'b0;
        endcase
        return set;
    endfunction

    function automatic logic cmp_err(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

`ifdef CMP_RR_EN
    logic rr_ptr;
`endif

    // Arbitration: ready is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        grant    = rst_n && (state == IDLE) && (req0_valid || req1_valid);
`ifdef CMP_RR_EN
        grant_id = (req0_valid && req1_valid) ? rr_ptr : ~req0_valid;
`else
        grant_id = ~req0_valid;
`endif
        req0_ready = grant & ~grant_id;
        req1_ready = grant & grant_id;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = EXEC;
            EXEC:    state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: operands captured on the grant edge.
    always_ff @(posedge clk) begin
        if (grant) begin
            op_p0 <= grant_id ? req1_op : req0_op;
            a_p0  <= grant_id ? req1_a  : req0_a;
            b_p0  <= grant_id ? req1_b  : req0_b;
            id_p0 <= grant_id;
        end
    end

    // Shared subtractor x - y = x + ~y + 1; SLE swaps the pair so its cout answers b >= a.
    always_comb begin
        sub_x    = (op_p0 == OP_SLE) ? b_p0 : a_p0;
        sub_y    = (op_p0 == OP_SLE) ? a_p0 : b_p0;
        sub_sum  = {1'b0, sub_x} + {1'b0, ~sub_y} + {{WIDTH{1'b0}}, 1'b1};
        sub_cout = sub_sum[WIDTH];
        sub_zero = (sub_sum[WIDTH-1:0] == '0);
    end

    // Stage p1: registered result, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_set   <= 1'b0;
            res_id    <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == EXEC) begin
                res_valid <= 1'b1;
                res_set   <= cmp_set(op_p0, sub_zero, sub_cout);
                res_err   <= cmp_err(op_p0);
                res_id    <= id_p0;
            end else if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef CMP_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= 1'b0;
        else if (grant)
            rr_ptr <= ~grant_id;
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Two-requester arbiter and sequencer for the shared 32-bit set-compare subtractor. Accepts compare requests from two issue ports through a valid/ready handshake, grants one at a time, and computes a − b as a + ~b + 1 in the single shared ripple subtractor. Produces a registered one-bit set result with the winning requester's ID. It sits between the issue logic and the write-back of set-instruction results.

## Interface
- WIDTH, 32, operand width; bit 0 is the LSB, and the carry enters at bit 0.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid / req1_valid  input  1  request present on port 0 / port 1.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_op / req1_op  input  3  compare opcode.
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
- res_valid  output  1  result held valid.
- res_ready  input  1  consumer accepts the result.
- res_set  output  1  compare outcome.
- res_id  output  1  requester that produced the result.
- res_err  output  1  illegal opcode flag.
- busy  output  1  state is not IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and HOLD.
- **IDLE**
  - If any reqN_valid is high, choose a winner by the arbitration rule.
  - Assert reqN_ready for the winner only, combinationally, in the same cycle.
  - Latch op, a, b and the winner's ID, then go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC**
  - Drive the shared subtractor with the latched operands and cin=1.
  - Derive zero = (diff == 0) and cout from the subtractor.
  - SLE uses the swapped operand pair b − a and takes its cout.
  - Register res_set and res_err, set res_valid=1, and go to HOLD.
- **HOLD**
  - Hold res_* stable while res_valid=1.
  - On res_valid & res_ready: clear res_valid, then go to IDLE.
  - A new request is not accepted in the same cycle as the result handshake.
- **Opcodes (unsigned)**
  - 000 SEQ: set = zero.
  - 001 SNE: set = ~zero.
  - 010 SGE: set = cout(a−b).
  - 011 SLE: set = cout(b−a).
  - 100 SGT: set = cout(a−b) & ~zero.
  - 101 SLT: set = ~cout(a−b).
  - 110 and 111: set=0 and res_err=1. This still occupies a full EXEC/HOLD cycle and the handshake proceeds normally.
- **Ready rules**
  - reqN_ready is 0 in EXEC and HOLD, and is never asserted without reqN_valid.
  - Requesters hold reqN_* stable until they see ready.
- The ignored subtractor cout/diff bits never reach the outputs.

## Timing
- **Reset:**
  - All outputs are 0 and the state is IDLE.
  - The round-robin pointer favours port 0.
  - Reset asserted mid-operation aborts immediately, and a pending result is lost.
- **Latency:**
  - Request accepted at edge N means res_valid=1 after edge N+1.
  - With res_ready held high, res_valid is high for exactly one cycle.
  - A back-to-back stream gives one result per 3 cycles.
- HOLD with res_ready low stalls indefinitely, and both ports see ready=0 for the whole stall.
- Simultaneous req0_valid and req1_valid produce exactly one grant per IDLE cycle. The loser keeps its valid high and is served on a later IDLE.
- Request inputs are sampled only in IDLE. Changes to them during EXEC or HOLD have no effect.

## Configuration
- **CMP_RR_EN defined:** round-robin arbitration.
  - After a grant to port N, port 1−N has priority on the next contested IDLE.
  - The pointer updates only on a grant.
- **CMP_RR_EN undefined:** fixed priority, with port 0 always winning ties.
  - The pointer logic is removed, and port 1 can starve.

## Test plan
- **Reset:** assert rst_n=0 mid-EXEC.
  - Required: all outputs go to 0 immediately.
  - Required: after release, a req0 SEQ with a=b=0x5 gives res_set=1, res_id=0 two cycles after acceptance.
- **Opcode sweep on port 1:**
  - a=3, b=7: SEQ 0, SNE 1, SGE 0, SLE 1, SGT 0, SLT 1.
  - a=7, b=7: SGE 1, SGT 0, SLE 1.
  - a=0xFFFFFFFF, b=1: SGT 1, which confirms unsigned compare.
- **Contention:** hold both ports valid for 4 requests.
  - With CMP_RR_EN: res_id sequence is 0,1,0,1.
  - Without it: res_id sequence is 0,0,0,0 while req0 stays valid.
- **Back-pressure:** hold res_ready=0 for 5 cycles in HOLD.
  - Required: res_* stay stable and both readys stay 0.
  - Required: on release, res_valid drops in the next cycle and the next request is accepted the following IDLE cycle.
- **Illegal opcode 111:** send it on port 0.
  - Required: res_err=1, res_set=0, res_valid after 2 cycles.
  - Required: the following legal request gives res_err=0.
- **Throughput:** stream SNE requests on port 0 with res_ready=1.
  - Required: req0_ready pulses every 3rd cycle, 3 cycles apart.
